// File: rtl/m1_wt_gen_if.sv
// Message/schedule/round bus for the SHA-256 message-schedule generator.
// The master side is the generator; the slave side is the surrounding
// datapath (message source, 16-deep schedule register, compression rounds).
interface m1_wt_gen_if;
  // Message word stream W0..W15
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  // Taps from the external 16-deep schedule shift register
  logic [31:0] w14_t_2;
  logic [31:0] w9_t_7;
  logic [31:0] w1_t_15;
  logic [31:0] w0_t_16;

  // Schedule register write port
  logic [31:0] w_in;
  logic        wt_reg_en;

  // W_t stream to the compression rounds
  logic [31:0] wt_data;
  logic [5:0]  wt_idx;
  logic        wt_valid;
  logic        wt_ready;

  modport master (
    input  m_data, m_valid,
    output m_ready,
    input  w14_t_2, w9_t_7, w1_t_15, w0_t_16,
    output w_in, wt_reg_en,
    output wt_data, wt_idx, wt_valid,
    input  wt_ready
  );

  modport slave (
    output m_data, m_valid,
    input  m_ready,
    output w14_t_2, w9_t_7, w1_t_15, w0_t_16,
    input  w_in, wt_reg_en,
    input  wt_data, wt_idx, wt_valid,
    output wt_ready
  );
endinterface

// File: rtl/m1_wt_gen.sv
// SHA-256 message-schedule generator and sequencer for the 1-core miner.
// Loads W0..W15 straight through from the message stream, then expands
// W16..W63 from the taps of an external 16-deep schedule shift register,
// handing every W_t to the compression rounds over valid/ready.
//
// Optional feature macro: M1_WT_RESTART_EN
//   defined   - a start pulse during LOAD/EXPAND aborts the block and
//               restarts loading at t=0 (no done pulse for the aborted block).
//   undefined - a start pulse during LOAD/EXPAND is ignored.
module m1_wt_gen #(
  parameter int ROUNDS     = 64,
  parameter int LOAD_WORDS = 16
) (
  input  logic clk_h,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  m1_wt_gen_if.master bus
);

  localparam logic [5:0] LAST_LOAD  = 6'(LOAD_WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  t;
  logic [31:0] w_next;
  logic [31:0] w_expand;
  logic        valid;
  logic        fire;
  logic        restart;

  // Small sigma functions of the SHA-256 message schedule
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef M1_WT_RESTART_EN
  // Any start pulse seen while a block is running restarts the load.
  assign restart = start;
`else
  // Start pulses during a running block are dropped.
  assign restart = 1'b0;
`endif

  // Expanded word straight from the register taps; valid once the previous
  // shift has settled, i.e. the cycle after the last accepted word.
  assign w_expand = sigma1(bus.w14_t_2) + bus.w9_t_7
                  + sigma0(bus.w1_t_15) + bus.w0_t_16;

  // Per-state datapath select: pass-through in LOAD, expansion in EXPAND,
  // quiet zeros otherwise so nothing undefined leaves the block.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_next      = '0;
    valid       = 1'b0;
    bus.m_ready = 1'b0;
    unique case (state)
      LOAD: begin
        w_next      = bus.m_data;
        valid       = bus.m_valid;
        bus.m_ready = bus.wt_ready;
      end
      EXPAND: begin
        w_next = w_expand;
        valid  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign fire          = valid & bus.wt_ready;
  assign bus.w_in      = w_next;
  assign bus.wt_data   = w_next;
  assign bus.wt_valid  = valid;
  assign bus.wt_reg_en = fire;
  assign bus.wt_idx    = t;

  // Block sequencer: round counter, busy and the one-cycle done pulse.
  always_ff @(posedge clk_h or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below reads the values from before this clock edge.
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            t     <= '0;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          if (restart) begin
            // A same-cycle fire still shifts the register; the word is
            // simply overwritten by the reload.
            t <= '0;
          end else if (fire) begin
            t <= t + 6'd1;
            if (t == LAST_LOAD) begin
              state <= EXPAND;
            end
          end
        end

        EXPAND: begin
          if (restart) begin
            state <= LOAD;
            t     <= '0;
          end else if (fire) begin
            if (t == LAST_ROUND) begin
              // Counter parks at the last round; it is cleared on the way out.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              t <= t + 6'd1;
            end
          end
        end

        DONE: begin
          t <= '0;
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m1_wt_gen.sv
// Self-checking bench for m1_wt_gen. Models the external 16-deep schedule
// register, drives the "abc" block under several handshake patterns, and
// checks every accepted W_t against a scoreboard queue filled by stimulus.
module tb_m1_wt_gen;

  logic clk_h = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  m1_wt_gen_if bus_if ();

  m1_wt_gen dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #5 clk_h = ~clk_h;

  // External schedule register: sched[15] holds the newest word.
  logic [31:0] sched [16];
  always @(posedge clk_h) begin
    if (bus_if.wt_reg_en) begin
      for (int i = 0; i < 15; i++) sched[i] <= sched[i + 1];
      sched[15] <= bus_if.w_in;
    end
  end
  assign bus_if.w14_t_2 = sched[14];
  assign bus_if.w9_t_7  = sched[9];
  assign bus_if.w1_t_15 = sched[1];
  assign bus_if.w0_t_16 = sched[0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference schedule for the "abc" block
  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
    for (int i = 16; i < 64; i++) begin
      logic [31:0] a, b;
      a = exp_w[i - 15];
      b = exp_w[i - 2];
      exp_w[i] = (rotr(b, 17) ^ rotr(b, 19) ^ (b >> 10)) + exp_w[i - 7]
               + (rotr(a, 7) ^ rotr(a, 18) ^ (a >> 3)) + exp_w[i - 16];
    end
  endtask

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q [$];

  task automatic push_words(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back('{idx: 6'(i), data: exp_w[i]});
  endtask

  // Monitor: pops one expectation per accepted word, plus per-cycle checks.
  int          done_cnt = 0;
  int          en_cnt   = 0;
  logic        prev_hold = 1'b0;
  logic        prev_fire63 = 1'b0;
  logic [31:0] prev_data = '0;
  logic [5:0]  prev_idx = '0;

  always @(negedge clk_h) begin
    logic f;
    exp_t e;
    if (!rst_n) begin
      prev_hold   <= 1'b0;
      prev_fire63 <= 1'b0;
    end else begin
      f = bus_if.wt_valid & bus_if.wt_ready;
      check("reg_en_eq_fire", 64'(bus_if.wt_reg_en), 64'(f));
      check("w_in_eq_wt_data", 64'(bus_if.w_in), 64'(bus_if.wt_data));
      if (prev_hold && bus_if.wt_valid) begin
        check("stall_data_stable", 64'(bus_if.wt_data), 64'(prev_data));
        check("stall_idx_stable", 64'(bus_if.wt_idx), 64'(prev_idx));
      end
      if (f) begin
        check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wt_idx", 64'(bus_if.wt_idx), 64'(e.idx));
          check("wt_data", 64'(bus_if.wt_data), 64'(e.data));
        end
        case (bus_if.wt_idx)
          6'd16: check("W16_const", 64'(bus_if.wt_data), 64'h61626380);
          6'd17: check("W17_const", 64'(bus_if.wt_data), 64'h000F0000);
          6'd18: check("W18_const", 64'(bus_if.wt_data), 64'h7DA86405);
          6'd63: check("W63_const", 64'(bus_if.wt_data), 64'h12B1EDEB);
          default: begin
          end
        endcase
      end
      if (done) begin
        check("done_after_w63", 64'(prev_fire63), 64'd1);
        done_cnt <= done_cnt + 1;
      end
      if (bus_if.wt_reg_en) en_cnt <= en_cnt + 1;
      prev_hold   <= bus_if.wt_valid & ~bus_if.wt_ready;
      prev_data   <= bus_if.wt_data;
      prev_idx    <= bus_if.wt_idx;
      prev_fire63 <= f && (bus_if.wt_idx == 6'd63);
    end
  end

  // Drives one or more blocks. rdy_mode 1 toggles wt_ready every cycle;
  // gap>0 raises m_valid every gap-th cycle; abort_idx/reset_idx (>=0) pulse
  // start / assert reset during the cycle that word is presented.
  task automatic run_block(input int rdy_mode, input int gap, input int nblocks,
                           input int abort_idx, input int reset_idx,
                           output int cyc_done);
    int k, cyc, dones, started, abort_cyc;
    logic f, fin;
    logic [5:0] idx;
    k = 0; cyc = 0; dones = 0; started = 1; abort_cyc = -10; fin = 1'b0;
    cyc_done = -1;
    start = 1'b1;
    bus_if.m_data   = msg[0];
    bus_if.m_valid  = 1'b1;
    bus_if.wt_ready = 1'b1;
    while (!fin) begin
      @(negedge clk_h);
      f   = bus_if.wt_valid & bus_if.wt_ready;
      idx = bus_if.wt_idx;
      if (done) begin
        dones++;
        if (dones == nblocks) begin
          fin = 1'b1;
          cyc_done = cyc;
        end
      end
      if (cyc > 600) begin
        checks++;
        errors++;
        $display("FAIL timeout: block not done after %0d cycles", cyc);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk_h);
        #1;
        cyc++;
        start = 1'b0;
        if (reset_idx >= 0 && f && int'(idx) == reset_idx - 1) begin
          rst_n = 1'b0;
          repeat (3) begin
            @(negedge clk_h);
            check("busy_in_reset", 64'(busy), 64'd0);
            check("done_in_reset", 64'(done), 64'd0);
          end
          @(posedge clk_h);
          #1;
          rst_n = 1'b1;
          fin = 1'b1;
        end else begin
          if (f && idx < 6'd16) k++;
          if (f && idx == 6'd63 && started < nblocks) begin
            start = 1'b1;
            k = 0;
            started++;
          end
          if (abort_idx >= 0 && f && int'(idx) == abort_idx - 1) begin
            start = 1'b1;
            abort_cyc = cyc;
          end
`ifdef M1_WT_RESTART_EN
          if (cyc == abort_cyc + 1) k = 0;
`endif
          bus_if.m_data   = (k < 16) ? msg[k] : 32'h0;
          bus_if.m_valid  = (k < 16) && (gap == 0 || cyc % gap == 0);
          bus_if.wt_ready = (rdy_mode == 0) || (cyc % 2 == 0);
        end
      end
    end
    @(posedge clk_h);
    #1;
    start = 1'b0;
    bus_if.m_valid  = 1'b0;
    bus_if.wt_ready = 1'b1;
  endtask

  initial begin
    int cyc, d0, e0;
    build_model();

    // Reset state, with live-looking inputs that must not leak through
    rst_n = 1'b0;
    start = 1'b0;
    bus_if.m_data   = 32'hDEADBEEF;
    bus_if.m_valid  = 1'b1;
    bus_if.wt_ready = 1'b1;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wt_valid", 64'(bus_if.wt_valid), 64'd0);
    check("rst_m_ready", 64'(bus_if.m_ready), 64'd0);
    check("rst_wt_idx", 64'(bus_if.wt_idx), 64'd0);
    check("rst_w_in", 64'(bus_if.w_in), 64'd0);
    check("rst_reg_en", 64'(bus_if.wt_reg_en), 64'd0);
    @(posedge clk_h);
    #1;
    rst_n = 1'b1;
    bus_if.m_valid = 1'b0;
    @(posedge clk_h);
    #1;

    // 1: "abc" block, all ready; 65 cycles start-to-done
    d0 = done_cnt;
    push_words(0, 63);
    run_block(0, 0, 1, -1, -1, cyc);
    check("t1_start_to_done", 64'(cyc), 64'd65);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // 2: wt_ready toggling 1-0-1
    d0 = done_cnt;
    e0 = en_cnt;
    push_words(0, 63);
    run_block(1, 0, 1, -1, -1, cyc);
    check("t2_reg_en_count", 64'(en_cnt - e0), 64'd64);
    check("t2_done_count", 64'(done_cnt - d0), 64'd1);

    // 3: m_valid every third cycle during LOAD
    d0 = done_cnt;
    push_words(0, 63);
    run_block(0, 3, 1, -1, -1, cyc);
    check("t3_done_count", 64'(done_cnt - d0), 64'd1);

    // 4: reset at t=30, then rerun the block
    d0 = done_cnt;
    push_words(0, 29);
    run_block(0, 0, 1, -1, 30, cyc);
    check("t4_no_done_on_reset", 64'(done_cnt - d0), 64'd0);
    check("t4_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t4_busy_after_reset", 64'(busy), 64'd0);
    d0 = done_cnt;
    push_words(0, 63);
    run_block(0, 0, 1, -1, -1, cyc);
    check("t4_rerun_done", 64'(done_cnt - d0), 64'd1);

    // 5: start while busy at t=40
    d0 = done_cnt;
`ifdef M1_WT_RESTART_EN
    push_words(0, 40);
    push_words(0, 63);
`else
    push_words(0, 63);
`endif
    run_block(0, 0, 1, 40, -1, cyc);
    check("t5_done_count", 64'(done_cnt - d0), 64'd1);
`ifndef M1_WT_RESTART_EN
    check("t5_start_to_done", 64'(cyc), 64'd65);
`endif

    // 6: start in the DONE cycle gives back-to-back blocks
    d0 = done_cnt;
    push_words(0, 63);
    push_words(0, 63);
    run_block(0, 0, 2, -1, -1, cyc);
    check("t6_two_blocks_cycles", 64'(cyc), 64'd130);
    check("t6_done_count", 64'(done_cnt - d0), 64'd2);

    repeat (3) @(posedge clk_h);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
